// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, byte/half/word access to a 32-bit-wide
// byte-addressed data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_t;

    // Every access touches four bytes, so the last legal base is MEM_BYTES-4.
    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

    state_t      state;
    state_t      state_next;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        req_err;
    logic [31:0] load_value;
    logic [31:0] merge_value;

    always_comb begin
        req_err = 1'b0;
        case (size_t'(req_size))
            SIZE_ILLEGAL: req_err = 1'b1;
            SIZE_HALF:    req_err = req_addr[0];
            SIZE_WORD:    req_err = (req_addr[1:0] != 2'b00);
            default:      req_err = 1'b0;
        endcase
        if (req_addr > ADDR_MAX) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        case (size_t'(size_q))
            SIZE_BYTE: load_value = {{24{signed_q & mem_read_data[7]}}, mem_read_data[7:0]};
            SIZE_HALF: load_value = {{16{signed_q & mem_read_data[15]}}, mem_read_data[15:0]};
            default:   load_value = mem_read_data;
        endcase
    end

    always_comb begin
        case (size_t'(size_q))
            SIZE_BYTE: merge_value = {mem_read_data[31:8], wdata_q[7:0]};
            SIZE_HALF: merge_value = {mem_read_data[31:16], wdata_q[15:0]};
            default:   merge_value = wdata_q;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!req_write) begin
                        state_next = LOAD;
                    end else if (size_t'(req_size) == SIZE_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_address     = addr_q;
                mem_read_enable = 1'b1;
                state_next      = RESP;
            end
            RMW_RD: begin
                mem_address     = addr_q;
                mem_read_enable = 1'b1;
                state_next      = WRITE;
            end
            WRITE: begin
                mem_address      = addr_q;
                mem_write_data   = merge_q;
                mem_write_enable = 1'b1;
                state_next       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all datapath registers are reset too, so outputs read zero immediately after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (req_write && size_t'(req_size) == SIZE_WORD) begin
                            merge_q <= req_wdata;
                        end
                    end
                end
                LOAD, RMW_RD: begin
                    // The read cycle either completes a load or feeds the store merge.
                    if (write_q) begin
                        merge_q <= merge_value;
                    end else begin
                        resp_rdata <= load_value;
                        resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, a mid-store reset,
// and randomized traffic checked against a byte-array reference model.
module tb_load_store_unit;

    localparam int MEM_BYTES = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] hold_rdata  = '0;
    logic        hold_err    = 1'b0;
    logic [31:0] last_rdata  = '0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational little-endian read, 4-byte write on the rising edge.
    always_comb begin
        mem_read_data = '0;
        if (mem_address <= 32'(MEM_BYTES - 4)) begin
            for (int i = 0; i < 4; i++) begin
                mem_read_data[8*i +: 8] = mem[mem_address[4:0] + 5'(i)];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable && mem_address <= 32'(MEM_BYTES - 4)) begin
            for (int i = 0; i < 4; i++) begin
                mem[mem_address[4:0] + 5'(i)] <= mem_write_data[8*i +: 8];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish within budget");
        $fatal(1, "simulation time budget exhausted");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour computed directly from the access rules on a byte array.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e_err, output logic [31:0] e_rdata,
                         output int e_lat, output int e_rds, output int e_wrs);
        int nbytes;
        nbytes  = 1 << sz;
        e_err   = (sz == 2'b11) || (a % nbytes != 0) || (a > 32'(MEM_BYTES - 4));
        e_rdata = '0;
        if (e_err) begin
            e_lat = 1; e_rds = 0; e_wrs = 0;
        end else if (!w) begin
            for (int i = 0; i < nbytes; i++) begin
                e_rdata = e_rdata | (32'(ref_mem[int'(a) + i]) << (8 * i));
            end
            if (sg && nbytes < 4 && e_rdata[8*nbytes-1]) begin
                e_rdata = e_rdata | (32'hFFFF_FFFF << (8 * nbytes));
            end
            e_lat = 2; e_rds = 1; e_wrs = 0;
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                ref_mem[int'(a) + i] = 8'(d >> (8 * i));
            end
            e_lat = (nbytes == 4) ? 2 : 3;
            e_rds = (nbytes == 4) ? 0 : 1;
            e_wrs = 1;
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_rds, e_wrs;
        int          lat, rds, wrs;
        bit          both, addr_bad, done;
        model(w, sz, sg, a, d, e_err, e_rdata, e_lat, e_rds, e_wrs);
        @(negedge clk);
        check("ready_in_idle", req_ready, 1);
        check("no_extra_resp", resp_valid, 0);
        check("hold_rdata", resp_rdata, hold_rdata);
        check("hold_err", resp_err, hold_err);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        lat = 0; rds = 0; wrs = 0; both = 0; addr_bad = 0; done = 0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_read_enable) rds++;
            if (mem_write_enable) wrs++;
            if (mem_read_enable && mem_write_enable) both = 1;
            if ((mem_read_enable || mem_write_enable) && mem_address !== a) addr_bad = 1;
            if (resp_valid === 1'b1) begin
                done       = 1;
                last_rdata = resp_rdata;
                check("resp_err", resp_err, e_err);
                check("resp_rdata", resp_rdata, e_rdata);
            end
            if (hold) begin
                req_write  = 1'($urandom);
                req_size   = 2'($urandom);
                req_signed = 1'($urandom);
                req_addr   = $urandom_range(0, MEM_BYTES - 1);
                req_wdata  = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
        check("resp_seen", done, 1);
        check("latency", lat, e_lat);
        check("read_strobes", rds, e_rds);
        check("write_strobes", wrs, e_wrs);
        check("strobe_overlap", both, 0);
        check("strobe_address", addr_bad, 0);
        hold_rdata = e_rdata;
        hold_err   = e_err;
    endtask

    initial begin
        int rst_resps;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < 8) begin
                case (i)
                    0: b = 8'h11; 1: b = 8'h22; 2: b = 8'h33; 3: b = 8'h44;
                    4: b = 8'h85; 5: b = 8'h66; 6: b = 8'h77; default: b = 8'h88;
                endcase
            end
            mem[i]     <= b;
            ref_mem[i] = b;
        end

        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        check("rst_mem_read_enable", mem_read_enable, 0);
        check("rst_mem_write_enable", mem_write_enable, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed loads, sub-word store and error cases against the preload.
        txn(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 1'b0);
        check("ldb_signed_4", last_rdata, 32'hFFFF_FF85);
        txn(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 1'b0);
        check("ldb_unsigned_4", last_rdata, 32'h0000_0085);
        txn(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0);
        check("ldw_0", last_rdata, 32'h4433_2211);
        txn(1'b1, 2'b00, 1'b0, 32'd1, 32'h0000_00AB, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0);
        check("ldw_0_after_stb", last_rdata, 32'h4433_AB11);
        txn(1'b0, 2'b01, 1'b0, 32'd1, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 1'b0, 32'd29, 32'h0, 1'b0);
        txn(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 1'b0);
        txn(1'b1, 2'b01, 1'b0, 32'd28, 32'h1234_BEEF, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 1'b0);

        // Reset pulsed during the WRITE cycle of a word store: write must be dropped.
        @(negedge clk);
        check("ready_before_rst_store", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr  = 32'd8; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        check("write_strobe_before_rst", mem_write_enable, 1);
        #1 rst = 1'b1;
        #1;
        check("write_strobe_dropped", mem_write_enable, 0);
        check("ready_in_rst", req_ready, 1);
        check("no_resp_in_rst", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_rdata = '0;
        hold_err   = 1'b0;
        rst_resps  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) rst_resps++;
        end
        check("no_resp_after_rst", rst_resps, 0);
        check("ready_after_rst", req_ready, 1);

        // Randomized traffic, sometimes with req_valid held high while busy.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
        end

        // Back-to-back alternating stores and loads with req_valid never dropped.
        for (int n = 0; n < 12; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 7) * 4);
            txn(n[0] ? 1'b0 : 1'b1, 2'(n % 3), 1'b1, a, $urandom, 1'b1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_traffic", req_ready, 1);

        for (int i = 0; i < MEM_BYTES; i++) begin
            check($sformatf("mem_byte_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 32, number of bytes in the attached data memory.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  unit accepts a request this cycle; high only in IDLE.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected; qualified by resp_valid.
REQ-014 mem_address  output  32  byte address to data memory.
REQ-015 mem_write_data  output  32  word to data memory; byte at mem_address in [7:0].
REQ-016 mem_read_enable  output  1  read strobe.
REQ-017 mem_write_enable  output  1  write strobe; memory writes bytes address..address+3 on rising edge.
REQ-018 mem_read_data  input  32  combinational little-endian word from bytes mem_address..mem_address+3.

Function
REQ-019 States SHALL be IDLE, LOAD, RMW_RD, WRITE, RESP; one request in flight at a time.
REQ-020 IDLE: req_ready=1; on req_valid the unit SHALL latch write, size, signed, addr and wdata, then transition.
REQ-021 Error if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr > MEM_BYTES-4 (memory always touches 4 bytes); error SHALL go IDLE->RESP with resp_err=1 and no mem strobe ever asserted.
REQ-022 Valid load: IDLE->LOAD; LOAD drives mem_address=latched addr, mem_read_enable=1; edge captures extended mem_read_data bits [7:0]/[15:0]/[31:0] into resp_rdata; ->RESP.
REQ-023 Valid store word: IDLE->WRITE with merge register = wdata.
REQ-024 Valid store byte/half: IDLE->RMW_RD; RMW_RD drives mem_read_enable=1; edge loads merge register = mem_read_data with [7:0] (byte) or [15:0] (half) replaced by wdata; ->WRITE.
REQ-025 WRITE: mem_write_enable=1, mem_write_data=merge register, mem_address=latched addr, for exactly one cycle; ->RESP.
REQ-026 RESP: resp_valid=1 for exactly one cycle, req_ready=0; ->IDLE.
REQ-027 Latency from accept edge to resp_valid high: error 1 cycle, load 2, store word 2, store byte/half 3.
REQ-028 req_valid while req_ready=0 SHALL be ignored; next request is accepted at the first IDLE cycle after RESP.
REQ-029 mem strobes SHALL be 0 outside LOAD/RMW_RD/WRITE; mem_read_enable and mem_write_enable never both 1.
REQ-030 resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-031 rst SHALL immediately force state IDLE and all registers and outputs to 0 except req_ready=1.
REQ-032 rst mid-operation SHALL drop any active mem strobe in the same cycle, abandon the request, and never produce resp_valid for it.

Verification
Memory preload bytes 0..7 = 11 22 33 44 85 66 77 88, MEM_BYTES=32.
REQ-033 Load byte signed addr 4 -> resp_valid 2 cycles after accept, resp_rdata=0xFFFFFF85; unsigned -> 0x00000085.
REQ-034 Load word addr 0 -> resp_rdata=0x44332211, resp_err=0.
REQ-035 Store byte 0xAB at addr 1 -> one RMW_RD cycle then one WRITE cycle, resp_valid 3 cycles after accept; subsequent load word addr 0 -> 0x4433AB11.
REQ-036 Load half addr 1; load byte addr 29; size=11 -> each resp_err=1 one cycle after accept, resp_rdata=0, no mem strobe.
REQ-037 Store word 0xDEADBEEF addr 8 with rst pulsed during WRITE -> mem_write_enable low in that cycle, no resp_valid, req_ready=1 after release.
REQ-038 req_valid held high continuously with alternating requests -> each accepted only in IDLE, one resp_valid per request, none lost or duplicated.
